// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone round-robin arbiter in front of one shared slave.
// A grant is held for the whole master cycle. A slave-ack watchdog ends a
// stalled strobe with a one-cycle error to the owning master. Expiries are
// counted in a saturating counter.
module wb_rr_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_dat_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_dat_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,

    output logic [1:0]  grant_o,
    output logic [7:0]  timeout_cnt_o
);

    // The state encoding is the one-hot grant vector itself.
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] GNT0 = 2'b01;
    localparam logic [1:0] GNT1 = 2'b10;

    // The watchdog fires in the cycle where it already holds TIMEOUT-1.
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

    logic [1:0] state_reg, state_next;
    logic       last_grant_reg, last_grant_next;
    logic [7:0] wd_reg, wd_next;
    logic [7:0] timeout_cnt_reg, timeout_cnt_next;
    // Holds the arbiter in IDLE for one edge after reset is released.
    logic       hold_reg;

    // Per-master views of the input buses, indexed by master number.
    logic        m_cyc [2];
    logic        m_stb [2];
    logic        m_we  [2];
    logic [3:0]  m_sel [2];
    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];

    assign m_cyc[0] = m0_cyc_i;  assign m_cyc[1] = m1_cyc_i;
    assign m_stb[0] = m0_stb_i;  assign m_stb[1] = m1_stb_i;
    assign m_we[0]  = m0_we_i;   assign m_we[1]  = m1_we_i;
    assign m_sel[0] = m0_sel_i;  assign m_sel[1] = m1_sel_i;
    assign m_adr[0] = m0_adr_i;  assign m_adr[1] = m1_adr_i;
    assign m_dat[0] = m0_dat_i;  assign m_dat[1] = m1_dat_i;

    logic granted;
    logic owner;
    logic own_cyc;
    logic own_stb;
    logic expire;

    assign granted = |state_reg;
    assign owner   = state_reg[1];
    assign own_cyc = granted & m_cyc[owner];
    assign own_stb = granted & m_stb[owner];
    // An ack in the limit cycle wins over the timeout.
    assign expire  = own_stb & ~s_ack_i & (wd_reg == WD_LIMIT);

    // Next-state logic: round-robin on ties, no preemption while cyc is held.
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (!hold_reg) begin
                    if (m_cyc[0] && m_cyc[1]) begin
                        state_next = last_grant_reg ? GNT0 : GNT1;
                    end else if (m_cyc[0]) begin
                        state_next = GNT0;
                    end else if (m_cyc[1]) begin
                        state_next = GNT1;
                    end
                end
                if (state_next == GNT0) last_grant_next = 1'b0;
                if (state_next == GNT1) last_grant_next = 1'b1;
            end
            GNT0: if (!m_cyc[0]) state_next = IDLE;
            GNT1: if (!m_cyc[1]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Watchdog and expiry counter next values.
    always_comb begin
        wd_next          = wd_reg;
        timeout_cnt_next = timeout_cnt_reg;
        if (!own_cyc || s_ack_i || expire) begin
            wd_next = 8'd0;
        end else if (own_stb) begin
            wd_next = wd_reg + 8'd1;
        end
        if (expire && timeout_cnt_reg != 8'hFF) begin
            timeout_cnt_next = timeout_cnt_reg + 8'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg       <= IDLE;
            last_grant_reg  <= 1'b1;
            wd_reg          <= 8'd0;
            timeout_cnt_reg <= 8'd0;
            hold_reg        <= 1'b1;
        end else begin
            state_reg       <= state_next;
            last_grant_reg  <= last_grant_next;
            wd_reg          <= wd_next;
            timeout_cnt_reg <= timeout_cnt_next;
            hold_reg        <= 1'b0;
        end
    end

    // Slave-side mux: mirror the owner, all zero when idle.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = 4'h0;
        s_adr_o = 32'h0;
        s_dat_o = 32'h0;
        if (granted) begin
            s_cyc_o = m_cyc[owner];
            s_stb_o = m_stb[owner] & ~expire;
            s_we_o  = m_we[owner];
            s_sel_o = m_sel[owner];
            s_adr_o = m_adr[owner];
            s_dat_o = m_dat[owner];
        end
    end

    // Master-side returns: only the owner sees ack, err and read data.
    logic        ack_vec [2];
    logic        err_vec [2];
    logic [31:0] rdat    [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ret
            assign ack_vec[gi] = state_reg[gi] & s_ack_i;
            assign err_vec[gi] = state_reg[gi] & expire;
            assign rdat[gi]    = state_reg[gi] ? s_dat_i : 32'h0;
        end
    endgenerate

    assign m0_ack_o = ack_vec[0];
    assign m0_err_o = err_vec[0];
    assign m0_dat_o = rdat[0];
    assign m1_ack_o = ack_vec[1];
    assign m1_err_o = err_vec[1];
    assign m1_dat_o = rdat[1];

    assign grant_o       = state_reg;
    assign timeout_cnt_o = timeout_cnt_reg;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed testbench for wb_rr_arbiter (TIMEOUT=16).
module tb_wb_rr_arbiter;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic        m0_ack_o, m0_err_o;
    logic [31:0] m0_dat_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic        m1_ack_o, m1_err_o;
    logic [31:0] m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic        s_ack_i;
    logic [31:0] s_dat_i;
    logic [1:0]  grant_o;
    logic [7:0]  timeout_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_rr_arbiter #(.TIMEOUT(16)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .grant_o(grant_o), .timeout_cnt_o(timeout_cnt_o)
    );

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    initial begin
        wb_rst_i = 1'b1;
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 0; m0_adr_i = 0; m0_dat_i = 0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 0; m1_adr_i = 0; m1_dat_i = 0;
        s_ack_i = 0; s_dat_i = 0;
        repeat (3) step();
        wb_rst_i = 1'b0;
        #1;
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_tcnt", 32'(timeout_cnt_o), 32'h0);
        chk("rst_scyc", 32'(s_cyc_o), 32'h0);
        chk("rst_m0dat", m0_dat_o, 32'h0);
        step();
        step();

        // Simultaneous request: master 0 first, then master 1 after one idle cycle.
        m0_cyc_i = 1; m1_cyc_i = 1;
        #1 chk("tie_pre", 32'(grant_o), 32'h0);
        step();
        chk("tie_gnt0", 32'(grant_o), 32'h1);
        m0_cyc_i = 0;
        step();
        chk("tie_idle", 32'(grant_o), 32'h0);
        step();
        chk("tie_gnt1", 32'(grant_o), 32'h2);
        m1_cyc_i = 0;
        step();
        chk("rel_idle", 32'(grant_o), 32'h0);

        // Master 0 write while master 1 also requests (last grant was master 1).
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF;
        m0_adr_i = 32'h3000_0010; m0_dat_i = 32'hA5A5_1234;
        m1_cyc_i = 1;
        step();
        chk("wr_grant", 32'(grant_o), 32'h1);
        chk("wr_adr", s_adr_o, 32'h3000_0010);
        chk("wr_dat", s_dat_o, 32'hA5A5_1234);
        chk("wr_sel", 32'(s_sel_o), 32'hF);
        chk("wr_we", 32'(s_we_o), 32'h1);
        chk("wr_stb", 32'(s_stb_o), 32'h1);
        s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
        #1;
        chk("wr_m0ack", 32'(m0_ack_o), 32'h1);
        chk("wr_m1ack", 32'(m1_ack_o), 32'h0);
        chk("wr_m1dat", m1_dat_o, 32'h0);
        step();
        s_ack_i = 0;
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
        m1_stb_i = 1; m1_we_i = 0; m1_sel_i = 4'h3; m1_adr_i = 32'h4000_0020;
        step();
        chk("rd_idle", 32'(grant_o), 32'h0);
        step();
        chk("rd_grant", 32'(grant_o), 32'h2);
        chk("rd_adr", s_adr_o, 32'h4000_0020);
        chk("rd_we", 32'(s_we_o), 32'h0);
        s_ack_i = 1; s_dat_i = 32'h1234_5678;
        #1;
        chk("rd_m1dat", m1_dat_o, 32'h1234_5678);
        chk("rd_m1ack", 32'(m1_ack_o), 32'h1);
        chk("rd_m0ack", 32'(m0_ack_o), 32'h0);
        step();
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        step();
        // Late ack while idle is discarded.
        s_ack_i = 1;
        #1;
        chk("late_m0ack", 32'(m0_ack_o), 32'h0);
        chk("late_m1ack", 32'(m1_ack_o), 32'h0);
        chk("late_grant", 32'(grant_o), 32'h0);
        s_ack_i = 0;

        // Slave never acks: error in the 16th strobe cycle.
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0;
        step();
        for (int k = 1; k < 16; k++) begin
            if (k == 15) chk("to_err15", 32'(m0_err_o), 32'h0);
            step();
        end
        chk("to_err16", 32'(m0_err_o), 32'h1);
        chk("to_stb16", 32'(s_stb_o), 32'h0);
        chk("to_ack16", 32'(m0_ack_o), 32'h0);
        chk("to_m1err", 32'(m1_err_o), 32'h0);
        step();
        chk("to_cnt1", 32'(timeout_cnt_o), 32'h1);
        chk("to_after", 32'(m0_err_o), 32'h0);
        chk("to_stb_re", 32'(s_stb_o), 32'h1);

        // Ack arriving in the 16th strobe cycle wins over the timeout.
        for (int k = 1; k < 16; k++) step();
        s_ack_i = 1;
        #1;
        chk("ackwin_ack", 32'(m0_ack_o), 32'h1);
        chk("ackwin_err", 32'(m0_err_o), 32'h0);
        step();
        s_ack_i = 0;
        chk("ackwin_cnt", 32'(timeout_cnt_o), 32'h1);
        m0_cyc_i = 0; m0_stb_i = 0;
        step();

        // 300 further timeouts: counter saturates at 255.
        m0_cyc_i = 1; m0_stb_i = 1;
        step();
        repeat (253 * 16) step();
        chk("sat_254", 32'(timeout_cnt_o), 32'd254);
        repeat (47 * 16) step();
        chk("sat_255", 32'(timeout_cnt_o), 32'd255);
        m0_cyc_i = 0; m0_stb_i = 0;
        step();

        // Reset during a master 1 read.
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0;
        step();
        chk("rr_gnt1", 32'(grant_o), 32'h2);
        wb_rst_i = 1; s_ack_i = 1;
        step();
        chk("rr_grant", 32'(grant_o), 32'h0);
        chk("rr_m1ack", 32'(m1_ack_o), 32'h0);
        chk("rr_tcnt", 32'(timeout_cnt_o), 32'h0);
        wb_rst_i = 0; s_ack_i = 0; m0_cyc_i = 1;
        step();
        chk("rr_hold", 32'(grant_o), 32'h0);
        step();
        chk("rr_m0win", 32'(grant_o), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: slave-ack watchdog limit in cycles, legal range 2..255.
REQ-002 SHALL have port wb_clk_i, input, 1 bit: sole clock; all state updates on rising edge.
REQ-003 SHALL have port wb_rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have ports mN_cyc_i, mN_stb_i, mN_we_i (N=0,1), input, 1 bit each: master N Wishbone cycle, strobe and write-enable.
REQ-005 SHALL have ports mN_sel_i, input, 4 bits: master N byte selects.
REQ-006 SHALL have ports mN_adr_i and mN_dat_i, input, 32 bits each: master N address and write data.
REQ-007 SHALL have ports mN_ack_o and mN_err_o, output, 1 bit each: master N acknowledge and timeout error.
REQ-008 SHALL have ports mN_dat_o, output, 32 bits: master N read data.
REQ-009 SHALL have ports s_cyc_o, s_stb_o, s_we_o, output, 1 bit each: shared slave cycle, strobe and write-enable.
REQ-010 SHALL have port s_sel_o, output, 4 bits, and ports s_adr_o and s_dat_o, output, 32 bits each: shared slave selects, address and write data.
REQ-011 SHALL have port s_ack_i, input, 1 bit, and port s_dat_i, input, 32 bits: slave acknowledge and read data.
REQ-012 SHALL have port grant_o, output, 2 bits: one-hot owner (bit N = master N), 00 when idle.
REQ-013 SHALL have port timeout_cnt_o, output, 8 bits: saturating count of watchdog expiries.

Function
REQ-014 SHALL implement FSM states IDLE, GNT0 and GNT1, with grant_o driven from the state register.
REQ-015 In IDLE with only mN_cyc_i high, SHALL move to GNTN on the next edge.
REQ-016 In IDLE with both cyc_i high, SHALL grant the master not recorded in last_grant; last_grant SHALL update on every grant.
REQ-017 In GNTN, SHALL hold the grant while mN_cyc_i stays high, with no preemption.
REQ-018 In GNTN, SHALL return to IDLE on the edge after mN_cyc_i falls, giving at least one IDLE cycle between grants.
REQ-019 In GNTN, s_cyc_o, s_we_o, s_sel_o, s_adr_o and s_dat_o SHALL combinationally mirror master N.
REQ-020 In GNTN, s_stb_o SHALL equal mN_stb_i, except that it SHALL be forced to 0 during the error cycle.
REQ-021 In IDLE, all s_* outputs SHALL be 0.
REQ-022 mN_ack_o SHALL equal s_ack_i only while in GNTN, and mN_dat_o SHALL equal s_dat_i only while in GNTN; the non-granted master SHALL see ack, err and dat all 0.
REQ-023 SHALL keep an 8-bit watchdog counter that increments each cycle s_stb_o=1 and s_ack_i=0, and clears on s_ack_i=1, on leaving GNTN, or in IDLE.
REQ-024 When the watchdog reaches TIMEOUT-1 with s_ack_i still 0, SHALL hold mN_err_o=1 for exactly that one cycle and hold mN_ack_o=0 in that cycle.
REQ-025 On watchdog expiry, SHALL clear the watchdog on the following edge and increment timeout_cnt_o, saturating at 255.
REQ-026 If s_ack_i and expiry coincide, ack SHALL win: no error, no timeout_cnt_o increment.
REQ-027 If cyc_i drops while stb is outstanding, SHALL release the grant per REQ-018; a late s_ack_i in IDLE SHALL be discarded.

Reset
REQ-028 While wb_rst_i=1 at an edge, SHALL set state=IDLE, last_grant=1 (so master 0 wins the first tie), watchdog=0 and timeout_cnt_o=0.
REQ-029 With state IDLE after reset, grant_o and all s_* and m*_ack/err/dat outputs SHALL be 0 from the edge after reset.
REQ-030 Reset asserted mid-transfer SHALL abort the grant with no ack or err delivered, and a new grant SHALL be issued no earlier than the second edge after reset deasserts.

Verification
REQ-031 Both cyc_i rise together after reset -> grant_o=01 next cycle; m0 releases -> 00 for one cycle, then 10.
REQ-032 m0 issues a write to 0x3000_0010 with data 0xA5A5_1234 and sel=0xF -> s_adr_o, s_dat_o and s_sel_o match; s_ack_i pulse reaches m0_ack_o only; m1_ack_o stays 0.
REQ-033 TIMEOUT=16, slave never acks -> m0_err_o=1 in the 16th strobe cycle; timeout_cnt_o=1; s_stb_o=0 in that cycle.
REQ-034 s_ack_i arrives exactly in the 16th strobe cycle -> m0_ack_o=1, m0_err_o=0, timeout_cnt_o unchanged.
REQ-035 Drive 300 consecutive timeouts -> timeout_cnt_o saturates at 255.
REQ-036 Assert wb_rst_i during a GNT1 read -> grant_o=00 and m1_ack_o=0; after release, with both requesting, master 0 is granted.
